// File: rtl/demux_defs_pkg.sv
// demux_defs: shared definitions for the demux16_router block.
//   WIDTH_DEF   default data word width
//   NCH_DEF     number of output channels (fixed at 4)
//   SEL_W       width of the destination select
//   CNT_W       width of the routed-transfer counter
//   ch_sel_e    channel index enumeration (register file, memory, I/O, debug)
//   sel_onehot  decodes a channel index into a one-hot channel mask
package demux_defs;

  localparam int WIDTH_DEF = 16;
  localparam int NCH_DEF   = 4;
  localparam int SEL_W     = 2;
  localparam int CNT_W     = 16;

  typedef enum logic [SEL_W-1:0] {
    CH_REGF = 2'd0,
    CH_MEM  = 2'd1,
    CH_IO   = 2'd2,
    CH_DBG  = 2'd3
  } ch_sel_e;

  function automatic logic [NCH_DEF-1:0] sel_onehot(input ch_sel_e sel);
    logic [NCH_DEF-1:0] hot;
    hot = '0;
    case (sel)
      CH_REGF: hot = 4'b0001;
      CH_MEM:  hot = 4'b0010;
      CH_IO:   hot = 4'b0100;
      CH_DBG:  hot = 4'b1000;
      default: hot = '0;
    endcase
    return hot;
  endfunction

endpackage

// File: rtl/demux_slot.sv
// demux_slot: one-entry holding register for a single output channel.
//   clock     system clock
//   reset     synchronous active-high reset (clears valid and data)
//   load      write ld_data into the slot this cycle (only asserted when free)
//   drain_rdy consumer ready; the held word leaves when valid && drain_rdy
//   ld_data   word to capture
//   valid     slot holds a word
//   data      held word
//   free      slot can accept a word this cycle (empty, or draining now)
module demux_slot
  import demux_defs::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             drain_rdy,
  input  logic [WIDTH-1:0] ld_data,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic             free
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;

  // A full slot that drains this cycle can take a new word on the same edge.
  assign free = !valid_q || drain_rdy;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = ld_data;
    end else if (valid_q && drain_rdy) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;

endmodule

// File: rtl/demux16_router.sv
// demux16_router: one-to-four 16-bit demultiplexer with per-channel
// one-entry holding slots and valid/ready handshakes.
//   clock, reset        system clock, synchronous active-high reset
//   in_data/in_sel      word to route and its destination channel
//   in_bcast            broadcast request (only honoured with DEMUX_BCAST_EN)
//   in_valid/in_ready   producer handshake
//   out_data            channel k data on bits [k*WIDTH +: WIDTH]
//   out_valid/out_ready per-channel consumer handshake
//   routed_cnt          count of accepted input transfers, wraps at 2^16
// Build option: define DEMUX_BCAST_EN to let in_bcast load all four slots
// with one transfer; otherwise in_bcast is ignored.
module demux16_router
  import demux_defs::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int NCH   = NCH_DEF
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     in_data,
  input  logic [SEL_W-1:0]     in_sel,
  input  logic                 in_bcast,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [NCH*WIDTH-1:0] out_data,
  output logic [NCH-1:0]       out_valid,
  input  logic [NCH-1:0]       out_ready,
  output logic [CNT_W-1:0]     routed_cnt
);

  logic [NCH-1:0]   sel_hot;
  logic [NCH-1:0]   slot_free;
  logic [NCH-1:0]   slot_load;
  logic             bcast_req;
  logic             accept;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign sel_hot = sel_onehot(ch_sel_e'(in_sel));

`ifdef DEMUX_BCAST_EN
  assign bcast_req = in_bcast;
`else
  logic unused_bcast;
  assign unused_bcast = in_bcast;
  assign bcast_req    = 1'b0;
`endif

  // Ready depends only on slot occupancy, out_ready and the select, never on
  // in_valid. Held low during reset so no handshake completes on that edge.
  always_comb begin
    in_ready = 1'b0;
    if (!reset) begin
      if (bcast_req) in_ready = &slot_free;
      else           in_ready = |(slot_free & sel_hot);
    end
  end

  assign accept = in_valid && in_ready;

  always_comb begin
    slot_load = '0;
    if (accept) slot_load = bcast_req ? '1 : sel_hot;
  end

  // A broadcast counts as one transfer.
  always_comb begin
    cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, accept};
  end

  always_ff @(posedge clock) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign routed_cnt = cnt_q;

  for (genvar k = 0; k < NCH; k++) begin : g_slot
    demux_slot #(.WIDTH(WIDTH)) u_slot (
      .clock     (clock),
      .reset     (reset),
      .load      (slot_load[k]),
      .drain_rdy (out_ready[k]),
      .ld_data   (in_data),
      .valid     (out_valid[k]),
      .data      (out_data[k*WIDTH +: WIDTH]),
      .free      (slot_free[k])
    );
  end

endmodule

// File: tb/tb_demux16_router.sv
module tb_demux16_router;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] in_data;
  logic [1:0]  in_sel;
  logic        in_bcast;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] out_data;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [15:0] routed_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  // Behavioural model: four word slots plus a transfer count.
  bit          m_v [4];
  logic [15:0] m_d [4];
  logic [15:0] m_cnt;
  logic        last_rdy;

  demux16_router dut (
    .clock      (clock),
    .reset      (reset),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .in_bcast   (in_bcast),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .routed_cnt (routed_cnt)
  );

  always #5 clock = ~clock;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic model_ready(input logic rst_i, input logic [1:0] s,
                                       input logic b, input logic [3:0] r);
    logic ok;
    if (rst_i) return 1'b0;
`ifdef DEMUX_BCAST_EN
    if (b) begin
      ok = 1'b1;
      for (int k = 0; k < 4; k++) if (m_v[k] && !r[k]) ok = 1'b0;
      return ok;
    end
`endif
    return !m_v[s] || r[s];
  endfunction

  // One clock cycle: drive inputs, check in_ready, clock, advance model,
  // check all registered outputs.
  task automatic step(input logic rst_i, input logic [15:0] d, input logic [1:0] s,
                      input logic b, input logic v, input logic [3:0] r);
    logic        exp_rdy;
    logic        bc;
    logic [3:0]  exp_v;
    logic [63:0] exp_d;
    reset = rst_i; in_data = d; in_sel = s; in_bcast = b; in_valid = v; out_ready = r;
    #1;
    exp_rdy  = model_ready(rst_i, s, b, r);
    last_rdy = in_ready;
    check("in_ready", {63'd0, in_ready}, {63'd0, exp_rdy});
    @(posedge clock);
    bc = 1'b0;
`ifdef DEMUX_BCAST_EN
    bc = b;
`endif
    if (rst_i) begin
      for (int k = 0; k < 4; k++) begin m_v[k] = 0; m_d[k] = '0; end
      m_cnt = '0;
    end else begin
      for (int k = 0; k < 4; k++) if (m_v[k] && r[k]) m_v[k] = 0;
      if (v && exp_rdy) begin
        for (int k = 0; k < 4; k++)
          if (bc || s == k[1:0]) begin m_v[k] = 1; m_d[k] = d; end
        m_cnt = m_cnt + 16'd1;
      end
    end
    #1;
    for (int k = 0; k < 4; k++) begin
      exp_v[k] = m_v[k];
      exp_d[k*16 +: 16] = m_d[k];
    end
    check("out_valid", {60'd0, out_valid}, {60'd0, exp_v});
    check("out_data", out_data, exp_d);
    check("routed_cnt", {48'd0, routed_cnt}, {48'd0, m_cnt});
  endtask

  initial begin
    for (int k = 0; k < 4; k++) begin m_v[k] = 0; m_d[k] = '0; end
    m_cnt = '0;
    @(negedge clock);

    // Reset state
    step(1, 16'h0, 0, 0, 0, 4'h0);
    step(1, 16'h0, 0, 0, 1, 4'h0);
    check("rst_ready", {63'd0, last_rdy}, 64'd0);
    check("rst_valid", {60'd0, out_valid}, 64'd0);
    check("rst_cnt", {48'd0, routed_cnt}, 64'd0);

    // Single word to channel 2, then drained
    step(0, 16'h1234, 2, 0, 1, 4'b0100);
    check("t1_valid", {60'd0, out_valid}, 64'h4);
    check("t1_data", {48'd0, out_data[47:32]}, 64'h1234);
    check("t1_cnt", {48'd0, routed_cnt}, 64'd1);
    step(0, 16'h0, 0, 0, 0, 4'b0100);
    check("t1_drained", {60'd0, out_valid}, 64'h0);

    // Stall on channel 1, independent traffic to channel 3
    step(0, 16'hAAAA, 1, 0, 1, 4'h0);
    check("st_rdy1", {63'd0, last_rdy}, 64'd1);
    step(0, 16'hBBBB, 1, 0, 1, 4'h0);
    check("st_rdy2", {63'd0, last_rdy}, 64'd0);
    check("st_hold", {48'd0, out_data[31:16]}, 64'hAAAA);
    step(0, 16'h5555, 3, 0, 1, 4'h0);
    check("st_rdy3", {63'd0, last_rdy}, 64'd1);
    check("st_valid", {60'd0, out_valid}, 64'hA);
    check("st_data3", {48'd0, out_data[63:48]}, 64'h5555);

    // Simultaneous drain and load on channel 0
    step(0, 16'h0, 0, 0, 0, 4'hF);
    step(0, 16'h0001, 0, 0, 1, 4'h0);
    step(0, 16'h0002, 0, 0, 1, 4'b0001);
    check("dl_rdy", {63'd0, last_rdy}, 64'd1);
    check("dl_valid0", {63'd0, out_valid[0]}, 64'd1);
    check("dl_data0", {48'd0, out_data[15:0]}, 64'h0002);

    // Reset with all slots full
    for (int k = 0; k < 4; k++) step(0, 16'hC000 + 16'(k), k[1:0], 0, 1, 4'h0);
    check("full_valid", {60'd0, out_valid}, 64'hF);
    step(1, 16'h0, 0, 0, 1, 4'h0);
    check("mr_rdy", {63'd0, last_rdy}, 64'd0);
    check("mr_valid", {60'd0, out_valid}, 64'h0);
    check("mr_data", out_data, 64'h0);
    check("mr_cnt", {48'd0, routed_cnt}, 64'd0);
    step(0, 16'h0, 1, 0, 0, 4'h0);
    check("mr_rdy_after", {63'd0, last_rdy}, 64'd1);

    // Broadcast request
    step(0, 16'hBEEF, 0, 1, 1, 4'h0);
`ifdef DEMUX_BCAST_EN
    check("bc_valid", {60'd0, out_valid}, 64'hF);
    check("bc_data", out_data, 64'hBEEF_BEEF_BEEF_BEEF);
`else
    check("bc_valid", {60'd0, out_valid}, 64'h1);
    check("bc_data", out_data, 64'h0000_0000_0000_BEEF);
`endif
    check("bc_cnt", {48'd0, routed_cnt}, 64'd1);
`ifdef DEMUX_BCAST_EN
    step(0, 16'h0, 0, 0, 0, 4'b1011);
`else
    step(0, 16'h7777, 2, 0, 1, 4'b1011);
`endif
    check("bc_ch2_full", {63'd0, out_valid[2]}, 64'd1);
    step(0, 16'h1111, 0, 1, 1, 4'h0);
`ifdef DEMUX_BCAST_EN
    check("bc_stall_rdy", {63'd0, last_rdy}, 64'd0);
`else
    check("bc_stall_rdy", {63'd0, last_rdy}, 64'd1);
`endif

    // Randomized traffic with occasional reset
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 63) == 0), 16'($urandom), 2'($urandom),
           1'($urandom_range(0, 7) == 0), 1'($urandom), 4'($urandom));
    end

    // Counter wrap
    step(1, 16'h0, 0, 0, 0, 4'h0);
    for (int i = 0; i < 65535; i++) step(0, 16'(i), 2'($urandom), 0, 1, 4'hF);
    check("wrap_ffff", {48'd0, routed_cnt}, 64'hFFFF);
    step(0, 16'h4242, 3, 0, 1, 4'hF);
    check("wrap_zero", {48'd0, routed_cnt}, 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/demux16_router.md
# demux16_router

One-to-four 16-bit demultiplexer with per-channel holding registers and valid/ready handshakes, the inverse of the datapath's 2-input/N-input 16-bit selection muxes. A single producer (ALU result / memory read path) presents a word plus a 2-bit destination select. The block steers the word to one of four consumers (register-file write port, memory write buffer, I/O port, debug tap). Each channel buffers one word, so a stalled consumer only blocks traffic addressed to it.

## Interface
Parameters:
- WIDTH, 16, data word width
- NCH, 4, number of output channels (fixed at 4; select is 2 bits)

Ports:
- clock  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- in_data  in  WIDTH  word to route
- in_sel  in  2  destination channel index
- in_bcast  in  1  broadcast request (used only with DEMUX_BCAST_EN)
- in_valid  in  1  producer has a word
- in_ready  out  1  word accepted this cycle when in_valid && in_ready
- out_data  out  NCH*WIDTH  channel k data on bits [k*WIDTH +: WIDTH]
- out_valid  out  NCH  channel k holds a word
- out_ready  in  NCH  consumer k takes the word this cycle
- routed_cnt  out  16  count of accepted input transfers, wraps

## Operation
- Each channel is a one-entry slot with two states:
  - EMPTY → FULL on load.
  - FULL → EMPTY on drain (out_valid[k] && out_ready[k]) without load.
  - FULL stays FULL on simultaneous drain + load, and the data is replaced.
- A slot is free when EMPTY, or when FULL and draining this cycle.
- Unicast readiness: in_ready = free(in_sel). This is combinational from out_ready and in_sel and has no dependency on in_valid.
- On accept, slot in_sel loads in_data, and routed_cnt increments by 1 (modulo 2^16, 0xFFFF → 0x0000).
- Slots not addressed hold their state; draining them proceeds independently.
- in_data and in_sel are don't-care when in_valid=0.
- During reset and on the cycle reset is asserted, in_ready=0 and no transfer occurs.
- Reset values:
  - out_valid = 0
  - out_data = 0
  - routed_cnt = 0
  - all slots EMPTY
- Reset mid-operation discards any held words. No handshake completes on that edge.

## Timing
- Latency: a word accepted at edge N is visible on out_data/out_valid after edge N (one cycle).
- Throughput: one word per cycle to any channel whose consumer holds out_ready=1.
- out_data[k] is stable while out_valid[k]=1 and out_ready[k]=0.
- out_valid[k] never drops without a drain, except on reset.
- Back-to-back words to the same channel with out_ready held high produce no bubble.
- The combinational path out_ready → in_ready is permitted. Consumers must not make out_ready depend on in_ready.

## Configuration
- DEMUX_BCAST_EN defined:
  - When in_bcast=1, in_ready = AND of free(k) over all k; in_sel is ignored.
  - On accept, all four slots load in_data, and routed_cnt increments by 1 (not 4).
- DEMUX_BCAST_EN undefined:
  - in_bcast is ignored entirely; behaviour is unicast only.
  - The port remains present so instantiations are identical in both builds.

## Structure
- Shared package/header demux_defs: WIDTH default, NCH, select width, and channel index constants:
  - CH_REGF=0
  - CH_MEM=1
  - CH_IO=2
  - CH_DBG=3
- One sub-module, demux_slot: a one-entry holding register with load/drain, valid flag and data register, instantiated NCH times.
- The top level holds select decode, ready generation, broadcast logic and routed_cnt.

## Test plan
- Reset release, then in_sel=2, in_data=0x1234, in_valid=1 for one cycle, out_ready=4'b0100 → out_valid=4'b0100 and out_data[47:32]=0x1234 one cycle later; drains next cycle; routed_cnt=1.
- Stall with out_ready=0:
  - Send 0xAAAA to ch1 → in_ready=1.
  - A second word to ch1 → in_ready=0; word held, 0xAAAA stable.
  - Meanwhile 0x5555 to ch3 → accepted.
- Simultaneous drain + load: ch0 FULL with 0x0001, out_ready[0]=1, new word 0x0002 to ch0 → accepted the same cycle; out_valid[0] stays 1 and out_data[15:0]=0x0002.
- Counter wrap:
  - Force 65535 accepted transfers, routed_cnt=0xFFFF.
  - One more → 0x0000.
- Reset mid-operation:
  - All slots FULL, assert reset one cycle → out_valid=0, out_data=0, routed_cnt=0, in_ready=0 during reset.
  - After release, in_ready=1.
- With DEMUX_BCAST_EN:
  - in_bcast=1, 0xBEEF, all free → all four out_valid set with 0xBEEF, routed_cnt +1.
  - With ch2 stalled FULL → in_ready=0.
- Without DEMUX_BCAST_EN: the same stimulus routes to in_sel only.
